uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side byte FIFO that sits behind a UART receiver. The receiver raises
// rx_done once a byte is assembled and may hold it high for several cycles.
// Only the rising edge of rx_done writes, so each received byte is stored
// exactly once. The consumer sees the head entry on d_out without any read
// latency (first-word-fall-through) and pops it with rd_en. If a byte arrives
// while the FIFO is full and nothing is popped in the same cycle, the byte is
// dropped and a sticky overflow flag is raised until clr_overflow or reset.
//
// Ports
//   clk           in   single clock, all state changes on the rising edge
//   reset         in   synchronous active-high reset
//   d_in          in   [SIZE-1:0]      received byte
//   rx_done       in   receiver byte-complete flag (level, edge-detected here)
//   rd_en         in   pop request from the consumer
//   clr_overflow  in   clears the sticky overflow flag
//   d_out         out  [SIZE-1:0]      head entry, 0 while empty
//   empty         out  count == 0
//   full          out  count == DEPTH
//   count         out  [DEPTH_LOG2:0]  number of stored entries, 0..DEPTH
//   overflow      out  sticky dropped-byte flag
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int SIZE       = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SIZE-1:0]       d_in,
    input  logic                  rx_done,
    input  logic                  rd_en,
    input  logic                  clr_overflow,
    output logic [SIZE-1:0]       d_out,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int                DEPTH    = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    // Storage and control state
    logic [SIZE-1:0]       r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_rx_done_p0;
    logic                  r_overflow;

    // Per-cycle decisions
    logic                  w_wr_evt;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    // Pointers are exactly DEPTH_LOG2 bits wide, so the natural carry-out
    // discard gives the DEPTH-1 -> 0 wrap.
    function automatic logic [DEPTH_LOG2-1:0] ptr_inc(input logic [DEPTH_LOG2-1:0] p);
        return p + DEPTH_LOG2'(1);
    endfunction

    // Occupancy update; the push/pop qualifiers already guarantee the result
    // stays inside 0..DEPTH.
    function automatic logic [DEPTH_LOG2:0] count_upd(input logic [DEPTH_LOG2:0] c,
                                                      input logic push,
                                                      input logic pop);
        logic [DEPTH_LOG2:0] n;
        n = c;
        if (push && !pop) begin
            n = c + (DEPTH_LOG2+1)'(1);
        end else if (pop && !push) begin
            n = c - (DEPTH_LOG2+1)'(1);
        end
        return n;
    endfunction

    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == CNT_FULL);
        // A high rx_done held across several cycles yields one event only.
        w_wr_evt    = rx_done && !r_rx_done_p0;
        w_pop       = rd_en && !w_empty;
        // When full, a byte may still be accepted because the simultaneous
        // pop frees the slot being written (count stays at DEPTH).
        w_push      = w_wr_evt && (!w_full || w_pop);
        w_drop      = w_wr_evt && !w_push;
        w_count_nxt = count_upd(r_count, w_push, w_pop);
    end

    // ---- stage p0: edge-detect register, pointers, count, overflow ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_done_p0 <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_rx_done_p0 <= rx_done;
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_nxt;
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage array is never cleared; stale contents are unreachable because
    // the pointers and count restart at zero.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= d_in;
        end
    end

    // ---- output: combinational head read, forced to 0 while empty ----
    always_comb begin
        d_out    = w_empty ? '0 : r_mem[r_rd_ptr];
        empty    = w_empty;
        full     = w_full;
        count    = r_count;
        overflow = r_overflow;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d_in;
    logic       rx_done;
    logic       rd_en;
    logic       clr_overflow;
    logic [7:0] d_out;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    uart_rx_fifo #(.SIZE(8), .DEPTH_LOG2(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .d_in         (d_in),
        .rx_done      (rx_done),
        .rd_en        (rd_en),
        .clr_overflow (clr_overflow),
        .d_out        (d_out),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a queue of stored bytes plus the sticky flag and the
    // previous rx_done level seen by the FIFO.
    byte unsigned mq[$];
    bit           m_ovf  = 1'b0;
    bit           m_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the model over the edge, compare.
    task automatic step(input bit rx, input logic [7:0] d, input bit rd,
                        input bit clr, input bit rst);
        bit evt;
        bit drop;
        reset        = rst;
        rx_done      = rx;
        d_in         = d;
        rd_en        = rd;
        clr_overflow = clr;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_prev = 1'b0;
        end else begin
            evt    = rx && !m_prev;
            m_prev = rx;
            drop   = 1'b0;
            if (rd && mq.size() > 0) void'(mq.pop_front());
            if (evt) begin
                if (mq.size() < 16) mq.push_back(d);
                else                drop = 1'b1;
            end
            if (drop)     m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        #1;
        check("count",    32'(count),    32'(mq.size()));
        check("empty",    32'(empty),    32'(mq.size() == 0));
        check("full",     32'(full),     32'(mq.size() == 16));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("d_out",    32'(d_out),    (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    endtask

    task automatic pulse(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
        step(1'b0, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);

        // Three single-cycle pulses, then three pops in order
        pulse(8'h41); pulse(8'h42); pulse(8'h43);
        check("abc_count", 32'(count), 32'd3);
        check("abc_head",  32'(d_out), 32'h41);
        pop(); pop(); pop();
        check("abc_empty", 32'(empty), 32'd1);
        check("abc_dout0", 32'(d_out), 32'd0);

        // Held rx_done writes once
        for (int i = 0; i < 5; i++) step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        check("hold_count", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        pulse(8'h56);
        check("hold_count2", 32'(count), 32'd2);
        pop(); pop();

        // Fill to full, drop the 17th, drain in order
        for (int i = 0; i < 16; i++) pulse(8'(i));
        check("fill_full", 32'(full), 32'd1);
        pulse(8'hAA);
        check("drop_count", 32'(count),    32'd16);
        check("drop_ovf",   32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) pop();
        check("drain_empty", 32'(empty), 32'd1);

        // Clear overflow, then reset with content, then write after reset
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("clr_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) pulse(8'(8'h60 + i));
        check("pre_rst_count", 32'(count), 32'd5);
        step(1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
        check("mid_rst_count", 32'(count), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        pulse(8'h12);
        check("post_rst_head", 32'(d_out), 32'h12);
        pop();

        // Write and pop together while full
        for (int i = 0; i < 16; i++) pulse(8'(i));
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check("fullrw_count", 32'(count), 32'd16);
        check("fullrw_head",  32'(d_out), 32'h01);
        check("fullrw_ovf",   32'(overflow), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) pop();
        check("fullrw_last", 32'(d_out), 32'h77);
        pop();

        // Write event with rd_en while empty: write wins, pop ignored
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        check("emptyrw_count", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Streaming 40 bytes across pointer wrap at low occupancy
        pulse(8'h03);
        for (int i = 1; i < 40; i++) begin
            step(1'b1, 8'(i * 7 + 3), 1'b0, 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        pop();
        check("stream_empty", 32'(empty),    32'd1);
        check("stream_ovf",   32'(overflow), 32'd0);

        // rx_done already high as reset releases counts as one write
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        check("rstrel_count", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with phases of varying pop pressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                bit rx, rd, clr, rst;
                rx  = ($urandom_range(0, 1) == 1);
                case (ph)
                    0:       rd = ($urandom_range(0, 9) == 0);
                    1:       rd = ($urandom_range(0, 1) == 0);
                    2:       rd = ($urandom_range(0, 9) != 0);
                    default: rd = ($urandom_range(0, 3) == 0);
                endcase
                clr = ($urandom_range(0, 19) == 0);
                rst = ($urandom_range(0, 299) == 0);
                step(rx, 8'($urandom), rd, clr, rst);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
